// File: rtl/prga.sv
// -----------------------------------------------------------------------------
// prga -- ARC4 pseudo-random generation stage.
//
// Works on the key-scheduled permutation S (256x8 RAM, left in place by ksa),
// reads a length-prefixed ciphertext from CT, produces the keystream, XORs it
// with the ciphertext and writes a length-prefixed plaintext to PT.
// A run is started with en while rdy=1; rdy drops for the whole run and comes
// back in the cycle after the last PT write.
//
// Ports
//   clk        in   1  system clock, all state changes on posedge
//   rst_n      in   1  synchronous active-low reset
//   en         in   1  start request, sampled only while rdy=1
//   rdy        out  1  idle and able to accept en
//   s_addr     out  8  S RAM address
//   s_rddata   in   8  S RAM read data (1-cycle latency)
//   s_wrdata   out  8  S RAM write data
//   s_wren     out  1  S RAM write enable
//   ct_addr    out  8  CT RAM address
//   ct_rddata  in   8  CT RAM read data (1-cycle latency)
//   pt_addr    out  8  PT RAM address
//   pt_rddata  in   8  PT RAM read data (not used by this stage)
//   pt_wrdata  out  8  PT RAM write data
//   pt_wren    out  1  PT RAM write enable
// -----------------------------------------------------------------------------
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_LEN  = 4'd1,
    GET_LEN = 4'd2,
    RD_SI   = 4'd3,
    GET_SI  = 4'd4,
    GET_SJ  = 4'd5,
    WR_SJ   = 4'd6,
    RD_PAD  = 4'd7,
    WR_PT   = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  // PT read port exists only so every memory has the same interface.
  logic unused_pt_rd;
  assign unused_pt_rd = ^pt_rddata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_d = RD_LEN;
      end

      RD_LEN: begin
        ct_addr = 8'd0;
        i_d     = 8'd0;
        j_d     = 8'd0;
        k_d     = 8'd1;
        state_d = GET_LEN;
      end

      // Length byte is copied straight through to pt[0].
      GET_LEN: begin
        len_d     = ct_rddata;
        pt_addr   = 8'd0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        state_d   = (ct_rddata == 8'd0) ? IDLE : RD_SI;
      end

      RD_SI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        state_d = GET_SI;
      end

      // Address S[j+S[i]] with the updated j in the same cycle to save a state.
      GET_SI: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_q + s_rddata;
        state_d = GET_SJ;
      end

      // Swap, first half: S[i] <= S[j].
      GET_SJ: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_SJ;
      end

      // Swap, second half: S[j] <= old S[i]. When i==j both writes hit the
      // same word with the same value, so S is left unchanged.
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        ct_addr  = k_q;
        state_d  = RD_PAD;
      end

      RD_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = WR_PT;
      end

      // k is compared before incrementing so L=255 ends without wrapping k.
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_SI;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
